acq_ctrl_multi: RTL

- Parametrised N-channel acquisition controller for the scope.
- Decimates ADC samples and writes them into the waveform RAM as a circular buffer with programmable pre-trigger depth.
- Edge trigger with hysteresis on any selected channel; auto, normal and single modes.
- Hands each completed record to the display side with a ready/ack handshake.

---
 rtl/acq_ctrl_multi_if.sv | 23 ++
 rtl/acq_ctrl_multi.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/acq_ctrl_multi_if.sv
// Waveform-RAM write port and display-side record handshake of the acquisition controller.
interface acq_ctrl_multi_if #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned SAMPLE_W = 14,
  parameter int unsigned ADDR_W   = 12
);
  logic [ADDR_W-1:0]       ram_addr;
  logic                    ram_wr_en;
  logic [NCH*SAMPLE_W-1:0] ram_data;
  logic [ADDR_W-1:0]       trig_addr;
  logic                    buf_ready;
  logic                    buf_ack;

  modport master (
    output ram_addr, ram_wr_en, ram_data, trig_addr, buf_ready,
    input  buf_ack
  );

  modport slave (
    input  ram_addr, ram_wr_en, ram_data, trig_addr, buf_ready,
    output buf_ack
  );
endinterface

// File: rtl/acq_ctrl_multi.sv
// N-channel scope acquisition controller: decimation, circular pre/post-trigger capture,
// hysteresis edge trigger with auto/normal/single modes and a ready/ack record handoff.
module acq_ctrl_multi #(
  parameter int unsigned NCH          = 2,
  parameter int unsigned SAMPLE_W     = 14,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned SEL_W        = 1,
  parameter int unsigned AUTO_TIMEOUT = 65535
) (
  input  logic                    clkin,
  input  logic                    rst,
  input  logic                    run_in,
  input  logic                    stop_in,
  input  logic [1:0]              trig_mode,
  input  logic [1:0]              trig_type,
  input  logic [SEL_W-1:0]        trig_src,
  input  logic [SAMPLE_W-1:0]     trig_lvl,
  input  logic [SAMPLE_W-1:0]     trig_hyst,
  input  logic [ADDR_W-1:0]       pretrig,
  input  logic [7:0]              acq_divider,
  input  logic [NCH*SAMPLE_W-1:0] adc_data,
  acq_ctrl_multi_if.master        bus,
  output logic                    state_runmode,
  output logic [2:0]              state_trig
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREFILL  = 3'd1,
    S_ARMED    = 3'd2,
    S_POSTFILL = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  localparam int unsigned TMO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam logic [SAMPLE_W-1:0] SMAX = '1;
  localparam logic [ADDR_W-1:0]   AMAX = '1;

  state_t                  state_q, state_d;
  logic [7:0]              div_q, div_d;
  logic [ADDR_W-1:0]       ptr_q, ptr_d;
  logic [ADDR_W-1:0]       fill_q, fill_d;
  logic [ADDR_W-1:0]       pre_q, pre_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    low_q, low_d;
  logic                    high_q, high_d;
  logic                    wr_q, wr_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [NCH*SAMPLE_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0]       taddr_q, taddr_d;
  logic                    rdy_q, rdy_d;

  logic [SAMPLE_W-1:0] sel_s;
  logic [SAMPLE_W:0]   lo_diff, hi_sum;
  logic [SAMPLE_W-1:0] lo_thr, hi_thr;
  logic                low_hit, high_hit, rise_ev, fall_ev, force_ev;
  logic                running, strobe;
  logic [ADDR_W-1:0]   post_n;

  // Out-of-range source indices fall back to channel 0.
  always_comb begin
    sel_s = adc_data[SAMPLE_W-1:0];
    for (int unsigned k = 1; k < NCH; k++) begin
      if (k == 32'(trig_src)) sel_s = adc_data[k*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_comb begin
    lo_diff  = {1'b0, trig_lvl} - {1'b0, trig_hyst};
    hi_sum   = {1'b0, trig_lvl} + {1'b0, trig_hyst};
    lo_thr   = lo_diff[SAMPLE_W] ? '0 : lo_diff[SAMPLE_W-1:0];
    hi_thr   = hi_sum[SAMPLE_W] ? SMAX : hi_sum[SAMPLE_W-1:0];
    low_hit  = sel_s < lo_thr;
    high_hit = sel_s > hi_thr;
    rise_ev  = trig_type[0] && low_q && (sel_s >= trig_lvl);
    fall_ev  = trig_type[1] && high_q && (sel_s <= trig_lvl);
    force_ev = (trig_mode == 2'd0) && (tmo_q == TMO_W'(AUTO_TIMEOUT - 1));
    running  = (state_q == S_PREFILL) || (state_q == S_ARMED) || (state_q == S_POSTFILL);
    strobe   = running && (div_q >= acq_divider);
    post_n   = AMAX - pre_q;
  end

  always_comb begin
    state_d = state_q;
    div_d   = running ? (strobe ? '0 : div_q + 8'd1) : '0;
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    pre_d   = pre_q;
    tmo_d   = tmo_q;
    low_d   = low_q;
    high_d  = high_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    taddr_d = taddr_q;
    rdy_d   = rdy_q;

    case (state_q)
      S_IDLE: begin
        if (run_in) begin
          state_d = S_PREFILL;
          pre_d   = pretrig;
          fill_d  = '0;
          low_d   = 1'b0;
          high_d  = 1'b0;
        end
      end
      S_PREFILL: begin
        if (strobe) begin
          low_d  = low_q | low_hit;
          high_d = high_q | high_hit;
          if (pre_q == '0) begin
            state_d = S_ARMED;
            tmo_d   = '0;
          end else begin
            wr_d   = 1'b1;
            addr_d = ptr_q;
            data_d = adc_data;
            ptr_d  = ptr_q + 1'b1;
            fill_d = fill_q + 1'b1;
            if (fill_q + 1'b1 == pre_q) begin
              state_d = S_ARMED;
              tmo_d   = '0;
            end
          end
        end
      end
      S_ARMED: begin
        if (strobe) begin
          wr_d   = 1'b1;
          addr_d = ptr_q;
          data_d = adc_data;
          ptr_d  = ptr_q + 1'b1;
          if (rise_ev || fall_ev || force_ev) begin
            taddr_d = ptr_q;
            state_d = S_POSTFILL;
            fill_d  = '0;
            low_d   = 1'b0;
            high_d  = 1'b0;
          end else begin
            low_d  = low_q | low_hit;
            high_d = high_q | high_hit;
            if (trig_mode == 2'd0) tmo_d = tmo_q + 1'b1;
          end
        end
      end
      S_POSTFILL: begin
        // Leave one cycle after the last strobe so its registered write lands before HOLD.
        if (fill_q == post_n) begin
          state_d = S_HOLD;
          rdy_d   = 1'b1;
        end else if (strobe) begin
          wr_d   = 1'b1;
          addr_d = ptr_q;
          data_d = adc_data;
          ptr_d  = ptr_q + 1'b1;
          fill_d = fill_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.buf_ack) begin
          rdy_d = 1'b0;
          if (trig_mode == 2'd2) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_PREFILL;
            pre_d   = pretrig;
            fill_d  = '0;
            low_d   = 1'b0;
            high_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (stop_in) begin
      state_d = S_IDLE;
      rdy_d   = 1'b0;
      wr_d    = 1'b0;
      ptr_d   = ptr_q;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      ptr_q   <= '0;
      fill_q  <= '0;
      pre_q   <= '0;
      tmo_q   <= '0;
      low_q   <= 1'b0;
      high_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      taddr_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
      pre_q   <= pre_d;
      tmo_q   <= tmo_d;
      low_q   <= low_d;
      high_q  <= high_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      taddr_q <= taddr_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.ram_addr   = addr_q;
  assign bus.ram_wr_en  = wr_q;
  assign bus.ram_data   = data_q;
  assign bus.trig_addr  = taddr_q;
  assign bus.buf_ready  = rdy_q;
  assign state_runmode  = (state_q != S_IDLE);
  assign state_trig     = state_q;

endmodule
